// File: rtl/pwm_pkg.sv
// pwm_pkg: constants shared by the PWM timer and the PWM capture block.
//   - register addresses of the 2-bit address / 16-bit data register port
//   - capture FSM state encoding
//   - default data/counter width
//   - bit positions inside the capture status word (address 0 read)
package pwm_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [1:0] ADDR_CTRL = 2'd0;
    localparam logic [1:0] ADDR_LOW  = 2'd1;
    localparam logic [1:0] ADDR_HIGH = 2'd2;
    localparam logic [1:0] ADDR_CNT  = 2'd3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_LOW  = 3'd2;
    localparam logic [2:0] ST_HIGH = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

endpackage

// File: rtl/pwm_edge_detect.sv
// pwm_edge_detect: brings the asynchronous PWM line into i_clk and produces
// single-cycle rise/fall pulses.
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_pwm             asynchronous PWM line
//   o_rise, o_fall    one-cycle edge pulses (3 cycles after the pin edge)
// Build option PWM_CAPTURE_GLITCH_FILTER_EN: a level is accepted only after
// three identical synchronised samples, so shorter pulses are dropped and
// edge latency grows to 5 cycles. Both edges get the same extra delay, so
// measured widths stay exact.
module pwm_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwm,
    output logic o_rise,
    output logic o_fall
);

    logic sync1;
    logic sync2;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       level;
    logic       stable;

    assign stable = (sync2 == hist[0]) && (sync2 == hist[1]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 2'b00;
            level <= 1'b0;
        end else begin
            sync1 <= i_pwm;
            sync2 <= sync1;
            hist  <= {hist[0], sync2};
            if (stable) level <= sync2;
        end
    end

    // Pulse in the cycle the filtered level is about to change.
    assign o_rise = stable &  sync2 & ~level;
    assign o_fall = stable & ~sync2 &  level;
`else
    logic prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= i_pwm;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign o_rise =  sync2 & ~prev;
    assign o_fall = ~sync2 &  prev;
`endif

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures low width, high width and period count of a PWM line.
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_pwm                    PWM line under measurement (asynchronous)
//   i_we, i_re, i_addr       register write / read strobes and address
//   i_wdata                  write data (addr0: N periods, 0 = abort)
//   o_rdata, o_rvalid        registered read data and its valid pulse
//   o_busy                   capture in progress
//   o_capture_done           one-cycle pulse on completion or timeout
// Build option PWM_CAPTURE_GLITCH_FILTER_EN enables the input glitch filter
// inside pwm_edge_detect.
//
// state | meaning
// IDLE  | not armed
// SYNC  | armed, waiting for a falling edge to start a low phase
// LOW   | counting low cycles
// HIGH  | counting high cycles; a falling edge closes the period
// DONE  | N periods captured or timed out; results held until re-arm
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwm,
    input  logic             i_we,
    input  logic             i_re,
    input  logic [1:0]       i_addr,
    input  logic [CNT_W-1:0] i_wdata,
    output logic [CNT_W-1:0] o_rdata,
    output logic             o_rvalid,
    output logic             o_busy,
    output logic             o_capture_done
);

    logic rise, fall;

    pwm_edge_detect u_edge (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pwm  (i_pwm),
        .o_rise (rise),
        .o_fall (fall)
    );

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d, high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_res_q, low_res_d, high_res_q, high_res_d;
    logic [CNT_W-1:0] period_q, period_d, period_inc;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] rd_mux, status_d;
    logic             busy_st, arm, abort;

    assign busy_st    = (state_q == ST_SYNC) || (state_q == ST_LOW) || (state_q == ST_HIGH);
    assign arm        = i_we && (i_addr == ADDR_CTRL) && (i_wdata != '0);
    assign abort      = i_we && (i_addr == ADDR_CTRL) && (i_wdata == '0);
    assign period_inc = period_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        low_cnt_d  = low_cnt_q;
        high_cnt_d = high_cnt_q;
        low_res_d  = low_res_q;
        high_res_d = high_res_q;
        period_d   = period_q;
        idle_d     = idle_q;
        timeout_d  = timeout_q;
        if (arm) begin
            // Arm beats any edge in the same cycle; the edge is dropped.
            state_d    = ST_SYNC;
            n_d        = i_wdata;
            low_cnt_d  = '0;
            high_cnt_d = '0;
            low_res_d  = '0;
            high_res_d = '0;
            period_d   = '0;
            timeout_d  = 1'b0;
            idle_d     = TIMEOUT;
        end else if (abort) begin
            state_d = ST_IDLE;
        end else if (busy_st && (idle_q == '0)) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
        end else begin
            // Idle timer is a down-counter reloaded on every accepted edge.
            if (busy_st) idle_d = idle_q - 1'b1;
            case (state_q)
                ST_SYNC: begin
                    if (fall) begin
                        state_d   = ST_LOW;
                        low_cnt_d = 1;
                        idle_d    = TIMEOUT;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_d    = ST_HIGH;
                        high_cnt_d = 1;
                        idle_d     = TIMEOUT;
                    end else if (low_cnt_q != '1) begin
                        low_cnt_d = low_cnt_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        low_res_d  = low_cnt_q;
                        high_res_d = high_cnt_q;
                        period_d   = period_inc;
                        idle_d     = TIMEOUT;
                        if (period_inc == n_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d   = ST_LOW;
                            low_cnt_d = 1;
                        end
                    end else if (high_cnt_q != '1) begin
                        high_cnt_d = high_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reads see post-write values so a same-cycle write is visible.
    always_comb begin
        status_d               = '0;
        status_d[STAT_BUSY]    = (state_d == ST_SYNC) || (state_d == ST_LOW) || (state_d == ST_HIGH);
        status_d[STAT_DONE]    = (state_d == ST_DONE);
        status_d[STAT_TIMEOUT] = timeout_d;
        case (i_addr)
            ADDR_CTRL: rd_mux = status_d;
            ADDR_LOW:  rd_mux = low_res_d;
            ADDR_HIGH: rd_mux = high_res_d;
            default:   rd_mux = period_d;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= ST_IDLE;
            n_q            <= '0;
            low_cnt_q      <= '0;
            high_cnt_q     <= '0;
            low_res_q      <= '0;
            high_res_q     <= '0;
            period_q       <= '0;
            idle_q         <= '0;
            timeout_q      <= 1'b0;
            o_rdata        <= '0;
            o_rvalid       <= 1'b0;
            o_capture_done <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            low_cnt_q      <= low_cnt_d;
            high_cnt_q     <= high_cnt_d;
            low_res_q      <= low_res_d;
            high_res_q     <= high_res_d;
            period_q       <= period_d;
            idle_q         <= idle_d;
            timeout_q      <= timeout_d;
            o_rvalid       <= i_re;
            if (i_re) o_rdata <= rd_mux;
            o_capture_done <= (state_d == ST_DONE) && (state_q != ST_DONE);
        end
    end

    assign o_busy = busy_st;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture.
module tb_pwm_capture;
    import pwm_pkg::*;

    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_pwm;
    logic         i_we;
    logic         i_re;
    logic [1:0]   i_addr;
    logic [W-1:0] i_wdata;
    logic [W-1:0] o_rdata;
    logic         o_rvalid;
    logic         o_busy;
    logic         o_capture_done;

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) if (o_capture_done === 1'b1) done_seen++;

    pwm_capture dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pwm          (i_pwm),
        .i_we           (i_we),
        .i_re           (i_re),
        .i_addr         (i_addr),
        .i_wdata        (i_wdata),
        .o_rdata        (o_rdata),
        .o_rvalid       (o_rvalid),
        .o_busy         (o_busy),
        .o_capture_done (o_capture_done)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int n);
        i_pwm = lvl;
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        i_we    = 1'b1;
        i_addr  = a;
        i_wdata = d;
        tick();
        i_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] exp, input string tag);
        i_re   = 1'b1;
        i_addr = a;
        tick();
        i_re   = 1'b0;
        check({tag, "_rvalid"}, W'(o_rvalid), 16'd1);
        check(tag, o_rdata, exp);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           k;
        int           changes;
        int           rv_bad;
        logic [W-1:0] prev;
        logic         seq[$];

        i_rst = 1'b1; i_pwm = 1'b1; i_we = 1'b0; i_re = 1'b0;
        i_addr = 2'd0; i_wdata = '0;
        tick(); tick();
        check("rst_rdata", o_rdata, 16'd0);
        check("rst_rvalid", W'(o_rvalid), 16'd0);
        check("rst_busy", W'(o_busy), 16'd0);
        check("rst_done", W'(o_capture_done), 16'd0);
        i_rst = 1'b0;
        tick();
        rd(ADDR_CTRL, 16'd0, "rst_status");

        // Normal capture, N=3, low 4 / high 6.
        repeat (5) tick();
        done_seen = 0;
        wr(ADDR_CTRL, 16'd3);
        check("arm_busy", W'(o_busy), 16'd1);
        for (int p = 0; p < 4; p++) begin
            drive(1'b0, 4);
            drive(1'b1, 6);
        end
        drive(1'b0, 10);
        check("n3_done_pulses", W'(done_seen), 16'd1);
        check("n3_busy_after", W'(o_busy), 16'd0);
        rd(ADDR_LOW, 16'd4, "n3_low");
        rd(ADDR_HIGH, 16'd6, "n3_high");
        rd(ADDR_CNT, 16'd3, "n3_cnt");
        rd(ADDR_CTRL, 16'd2, "n3_status");

        // Timeout with the line held low.
        done_seen = 0;
        wr(ADDR_CTRL, 16'd5);
        k = 0;
        while (k < 70000 && o_capture_done !== 1'b1) begin
            tick();
            k++;
        end
        checks++;
        assert (k == 65536) else begin
            errors++;
            $error("FAIL timeout_latency: observed %0d expected %0d", k, 65536);
        end
        rd(ADDR_CTRL, 16'd6, "to_status");
        rd(ADDR_CNT, 16'd0, "to_cnt");
        rd(ADDR_LOW, 16'd0, "to_low");

        // Re-arm after one period.
        drive(1'b1, 6);
        done_seen = 0;
        wr(ADDR_CTRL, 16'd2);
        drive(1'b0, 4);
        drive(1'b1, 6);
        drive(1'b0, 5);
        rd(ADDR_CNT, 16'd1, "rearm_pre_cnt");
        wr(ADDR_CTRL, 16'd2);
        check("rearm_busy", W'(o_busy), 16'd1);
        rd(ADDR_CNT, 16'd0, "rearm_cnt_clr");
        rd(ADDR_LOW, 16'd0, "rearm_low_clr");
        drive(1'b0, 3);
        drive(1'b1, 6);
        drive(1'b0, 4);
        drive(1'b1, 6);
        drive(1'b0, 4);
        drive(1'b1, 6);
        drive(1'b0, 8);
        check("rearm_done_pulses", W'(done_seen), 16'd1);
        rd(ADDR_CNT, 16'd2, "rearm_cnt");
        rd(ADDR_LOW, 16'd4, "rearm_low");
        rd(ADDR_HIGH, 16'd6, "rearm_high");

        // Reset in the middle of a HIGH phase.
        wr(ADDR_CTRL, 16'd3);
        drive(1'b1, 6);
        drive(1'b0, 4);
        drive(1'b1, 6);
        drive(1'b0, 4);
        i_pwm = 1'b1;
        rd(ADDR_LOW, 16'd4, "mid_low");
        drive(1'b1, 4);
        check("mid_busy", W'(o_busy), 16'd1);
        i_rst = 1'b1;
        #1;
        check("mid_rst_rdata", o_rdata, 16'd0);
        check("mid_rst_busy", W'(o_busy), 16'd0);
        check("mid_rst_rvalid", W'(o_rvalid), 16'd0);
        check("mid_rst_done", W'(o_capture_done), 16'd0);
        tick();
        i_rst = 1'b0;
        tick();
        rd(ADDR_LOW, 16'd0, "mid_low_clr");
        rd(ADDR_HIGH, 16'd0, "mid_high_clr");
        rd(ADDR_CNT, 16'd0, "mid_cnt_clr");
        rd(ADDR_CTRL, 16'd0, "mid_status");

        // Continuous reads of addr2 while capturing, N=2, high 5 then 7.
        drive(1'b1, 3);
        wr(ADDR_CTRL, 16'd2);
        i_re = 1'b1;
        i_addr = ADDR_HIGH;
        seq.delete();
        repeat (4) seq.push_back(1'b0);
        repeat (5) seq.push_back(1'b1);
        repeat (4) seq.push_back(1'b0);
        repeat (7) seq.push_back(1'b1);
        repeat (8) seq.push_back(1'b0);
        prev = 16'd0;
        changes = 0;
        rv_bad = 0;
        foreach (seq[i]) begin
            i_pwm = seq[i];
            tick();
            if (o_rvalid !== 1'b1) rv_bad++;
            if (o_rdata !== prev) begin
                changes++;
                prev = o_rdata;
            end
        end
        i_re = 1'b0;
        check("stream_rvalid_gaps", W'(rv_bad), 16'd0);
        check("stream_changes", W'(changes), 16'd2);
        check("stream_final", o_rdata, 16'd7);
        tick();
        check("stream_rvalid_drop", W'(o_rvalid), 16'd0);

        // Glitch inside a 20-cycle low phase; arm with same-cycle status read.
        drive(1'b1, 6);
        i_we = 1'b1; i_re = 1'b1; i_addr = ADDR_CTRL; i_wdata = 16'd1;
        tick();
        i_we = 1'b0; i_re = 1'b0;
        check("wr_rd_same_rvalid", W'(o_rvalid), 16'd1);
        check("wr_rd_same_status", o_rdata, 16'd1);
        drive(1'b0, 5);
        drive(1'b1, 1);
        drive(1'b0, 14);
        drive(1'b1, 6);
        drive(1'b0, 8);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        rd(ADDR_LOW, 16'd20, "glitch_low");
        rd(ADDR_HIGH, 16'd6, "glitch_high");
`else
        rd(ADDR_LOW, 16'd5, "glitch_low");
        rd(ADDR_HIGH, 16'd1, "glitch_high");
`endif
        rd(ADDR_CNT, 16'd1, "glitch_cnt");
        wr(ADDR_LOW, 16'h1234);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        rd(ADDR_LOW, 16'd20, "ro_low");
`else
        rd(ADDR_LOW, 16'd5, "ro_low");
`endif
        wr(ADDR_CTRL, 16'd0);
        rd(ADDR_CTRL, 16'd0, "abort_status");
        rd(ADDR_CNT, 16'd1, "abort_cnt_kept");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receiving end of the PWM timer interface: samples a PWM line and measures low-phase width, high-phase width and number of complete periods.
- Exposes the results through the same 2-bit-address / 16-bit-data register style the timer uses for writes, plus a read strobe.
- Sits beside timer_mealy in loopback test setups and on boards that monitor an external PWM source.

Parameters:
- CNT_W, 16, width of the width counters, period counter and data bus.
- TIMEOUT, 16'hFFFF, idle cycles without an accepted edge before a capture aborts.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_pwm  input  1  PWM line under measurement; asynchronous to i_clk.
- i_we  input  1  register write strobe.
- i_re  input  1  register read strobe.
- i_addr  input  2  register address.
- i_wdata  input  CNT_W  write data.
- o_rdata  output  CNT_W  read data, registered.
- o_rvalid  output  1  one-cycle pulse; o_rdata is valid in this cycle.
- o_busy  output  1  high while a capture is in progress.
- o_capture_done  output  1  one-cycle pulse when a capture finishes, whether normal or timeout.

Behaviour:
- Reset (asynchronous, i_rst=1): all outputs 0; state IDLE; all counters and result registers 0; synchroniser flops 0.
- Input path:
  - 2-flop synchroniser, then a previous-value register; rise/fall are detected on the synchronised signal.
  - Edge-detect latency is 3 cycles from the i_pwm transition. Both edges are delayed equally, so measured widths are exact in i_clk cycles.
- Register map:
  - addr0 write: N = i_wdata. N≠0 arms a capture (clears results, enters SYNC). N=0 aborts to IDLE with results kept.
  - addr0 read: {13'b0, timeout, done, busy}.
  - addr1 read: low width of the last complete period.
  - addr2 read: high width of the last complete period.
  - addr3 read: number of complete periods counted.
  - Writes to addr1–3 are ignored.
- Read timing: o_rdata and o_rvalid update 1 cycle after i_re. o_rdata holds its value otherwise. If i_we and i_re occur in the same cycle, the write applies first, and a read of addr0 returns the post-write status.
- FSM states: IDLE, SYNC, LOW, HIGH, DONE.
  - IDLE: busy=0. Arm → SYNC.
  - SYNC: busy=1. Waits for a falling edge to align to the start of a low phase → LOW with low_cnt=1.
  - LOW: low_cnt++ each cycle. On a rising edge: high_cnt=1 → HIGH.
  - HIGH: high_cnt++ each cycle. On a falling edge:
    - addr1 ← low_cnt, addr2 ← high_cnt, period_cnt++.
    - If period_cnt+1 == N → DONE; else → LOW with low_cnt=1.
  - DONE: done=1, busy=0. Pulses o_capture_done in the entry cycle only. Stays until a re-arm.
- Timeout:
  - An idle counter resets on every accepted edge and on arm.
  - In SYNC/LOW/HIGH, reaching TIMEOUT sets the timeout bit and goes to DONE, keeping the last complete results.
  - The timeout bit clears on arm.
- Width counters saturate at all-ones; they never wrap.
- Re-arm while busy or done restarts the capture from SYNC in the next cycle and clears results, done and timeout.
- Edge and arm in the same cycle: arm wins, and the edge is discarded.
- Reset mid-capture returns immediately to the full reset state.

Optional Feature:
- Macro: PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined:
  - The synchronised level is accepted only after it is stable for 3 consecutive cycles.
  - Pulses shorter than 3 cycles are ignored.
  - Edge latency becomes 5 cycles; measured widths are unchanged for pulses of 3 cycles or more.
- Undefined: no filter; every synchronised transition is an edge.

Decomposition:
- Shared package pwm_pkg contains:
  - register address constants ADDR_CTRL=0, ADDR_LOW=1, ADDR_HIGH=2, ADDR_CNT=3;
  - FSM state encoding (3-bit localparams);
  - the CNT_W default;
  - status bit positions.
- The timer may reuse the address constants.
- Sub-module pwm_edge_detect: synchroniser, optional glitch filter and rise/fall pulse generation. It keeps the FSM file free of metastability logic.

Test Plan:
- Arm N=3; drive PWM low 4 / high 6 cycles (period 10), synchronous, for 4 periods → o_capture_done after the 3rd falling edge; reads return addr1=4, addr2=6, addr3=3, addr0=3'b010.
- Arm N=5; PWM held constant low → after 65535 idle cycles, o_capture_done pulses; addr0=3'b110, addr3=0.
- Arm N=2; after 1 period, write N=2 again → results clear, busy stays 1; completes after 2 further periods with addr3=2.
- Assert i_rst in the middle of a HIGH phase → all outputs 0 in the same cycle; state IDLE; addr1–3 read 0.
- Issue i_re to addr2 each cycle during a capture → o_rvalid is 1 cycle after each i_re; data changes only in the cycle after a falling edge is accepted.
- With PWM_CAPTURE_GLITCH_FILTER_EN: insert a 1-cycle high glitch inside a 20-cycle low phase → the glitch is ignored and addr1=20; without the macro, the same stimulus gives addr1 equal to the low cycles before the glitch.
